shift_unit: RTL and testbench

Parametrised, multi-cycle shift/rotate unit for the stack processor datapath. It replaces the fixed-width, fixed-distance combinational left shifter with a sequential unit. The unit supports logical left, logical right, arithmetic right and rotate-left by a run-time amount, and uses a start/done handshake. It sits beside the ALU and is driven by the control unit for shift-class instructions, which stall until `done`.

---
 rtl/shift_unit.sv | 112 +++++++++++
 tb/tb_shift_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// shift_unit: sequential shift/rotate unit for the stack processor datapath.
// Performs SLL, SRL, SRA or ROL by a run-time amount, one bit per cycle,
// with a start/done handshake. Operands are captured when start is accepted.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; result/carry hold the last operation
// ST_SHIFT | one 1-bit step per cycle until cnt reaches 1
// ST_DONE  | done pulse; result/carry valid, returns to ST_IDLE
module shift_unit #(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    logic [1:0]       state;
    logic [1:0]       mode_q;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] step_result;
    logic             step_carry;

    // Single-bit step of the captured operation applied to the current result.
    always_comb begin
        step_result = result;
        step_carry  = 1'b0;
        case (mode_q)
            MODE_SLL: begin
                step_carry  = result[WIDTH-1];
                step_result = {result[WIDTH-2:0], 1'b0};
            end
            MODE_SRL: begin
                step_carry  = result[0];
                step_result = {1'b0, result[WIDTH-1:1]};
            end
            MODE_SRA: begin
                step_carry  = result[0];
                step_result = {result[WIDTH-1], result[WIDTH-1:1]};
            end
            MODE_ROL: begin
                step_carry  = result[WIDTH-1];
                step_result = {result[WIDTH-2:0], result[WIDTH-1]};
            end
            default: begin
                step_result = result;
                step_carry  = 1'b0;
            end
        endcase
    end

    // Sequencer and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            mode_q <= MODE_SLL;
            cnt    <= '0;
            result <= '0;
            carry  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        result <= data_in;
                        mode_q <= mode;
                        cnt    <= amount;
                        carry  <= 1'b0;
                        state  <= (amount == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    result <= step_result;
                    carry  <= step_carry;
                    cnt    <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs are pure state decodes, so no input reaches them combinationally.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: drives 8/16/32-bit shift_unit instances and compares against
// an arithmetic reference model of the four shift/rotate operations.
module tb_shift_unit;

    logic        clk;
    logic        reset;
    logic        start_v [3];
    logic [1:0]  mode;
    logic [31:0] data;
    logic [4:0]  amount;
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        carry_v [3];
    logic [7:0]  res8;
    logic [15:0] res16;
    logic [31:0] res32;
    logic [31:0] res_v   [3];

    int n_chk = 0;
    int n_err = 0;

    shift_unit #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start_v[0]), .mode(mode),
        .data_in(data[7:0]), .amount(amount[2:0]), .busy(busy_v[0]),
        .done(done_v[0]), .result(res8), .carry(carry_v[0])
    );
    shift_unit #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .start(start_v[1]), .mode(mode),
        .data_in(data[15:0]), .amount(amount[3:0]), .busy(busy_v[1]),
        .done(done_v[1]), .result(res16), .carry(carry_v[1])
    );
    shift_unit #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .start(start_v[2]), .mode(mode),
        .data_in(data), .amount(amount), .busy(busy_v[2]),
        .done(done_v[2]), .result(res32), .carry(carry_v[2])
    );

    assign res_v[0] = {24'd0, res8};
    assign res_v[1] = {16'd0, res16};
    assign res_v[2] = res32;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int wof(input int u);
        return (u == 0) ? 8 : ((u == 1) ? 16 : 32);
    endfunction

    // Reference: the whole shift computed at once from the operation's definition.
    function automatic void model(input int w, input logic [1:0] m, input logic [31:0] d,
                                  input int a, output logic [31:0] r, output logic c);
        longint unsigned mask, dd, rr, sgn;
        mask = (64'd1 << w) - 64'd1;
        dd   = 64'(d) & mask;
        sgn  = (dd >> (w - 1)) & 64'd1;
        case (m)
            2'b00:   rr = (dd << a) & mask;
            2'b01:   rr = dd >> a;
            2'b10:   rr = (dd >> a) | ((sgn != 0) ? (mask & ~(mask >> a)) : 64'd0);
            default: rr = ((dd << a) | (dd >> (w - a))) & mask;
        endcase
        r = 32'(rr);
        if (a == 0)                 c = 1'b0;
        else if (m[0] ^ m[1])       c = 1'((dd >> (a - 1)) & 64'd1);
        else                        c = 1'((dd >> (w - a)) & 64'd1);
    endfunction

    // One operation on instance u; checks value, latency, busy window and hold.
    task automatic do_op(input int u, input logic [1:0] m, input logic [31:0] d,
                         input int a, input bit disturb,
                         output logic [31:0] r, output logic c);
        logic [31:0] er;
        logic        ec;
        bit          busy_ok = 1;
        bit          seen = 0;
        int          lat = 0;
        model(wof(u), m, d, a, er, ec);
        r = '0;
        c = 1'b0;
        @(negedge clk);
        mode = m; data = d; amount = 5'(a); start_v[u] = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(negedge clk);
            if (!busy_v[u]) busy_ok = 0;
            if (done_v[u]) begin
                seen = 1; lat = cyc; r = res_v[u]; c = carry_v[u];
            end
            if (disturb) begin
                start_v[u] = 1'b1;
                mode = 2'($urandom); data = $urandom; amount = 5'($urandom);
            end else begin
                start_v[u] = 1'b0;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("busy_window", 64'(busy_ok), 64'd1);
        chk("latency", 64'(lat), 64'(a + 1));
        chk("result", 64'(r), 64'(er));
        chk("carry", 64'(c), 64'(ec));
        @(negedge clk);
        start_v[u] = 1'b0;
        chk("idle_after_done", 64'(busy_v[u]), 64'd0);
        chk("result_hold", 64'(res_v[u]), 64'(er));
        chk("carry_hold", 64'(carry_v[u]), 64'(ec));
    endtask

    logic [31:0] r;
    logic        c;

    initial begin
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        mode = 2'b00; data = '0; amount = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", 64'(busy_v[i]), 64'd0);
            chk("rst_done", 64'(done_v[i]), 64'd0);
            chk("rst_result", 64'(res_v[i]), 64'd0);
            chk("rst_carry", 64'(carry_v[i]), 64'd0);
        end

        // Directed cases at all three widths.
        for (int u = 0; u < 3; u++) begin
            do_op(u, 2'b00, 32'd12, 2, 0, r, c);
            chk("sll_12_2", 64'(r), 64'd48);
            do_op(u, 2'b10, (32'd1 << (wof(u) - 1)) | 32'd1, 1, 0, r, c);
            chk("sra_msb_1", 64'(r), 64'd3 << (wof(u) - 2));
            chk("sra_carry", 64'(c), 64'd1);
            do_op(u, 2'b01, (32'd1 << (wof(u) - 1)) | 32'd1, 1, 0, r, c);
            chk("srl_msb_1", 64'(r), 64'd1 << (wof(u) - 2));
            chk("srl_carry", 64'(c), 64'd1);
        end
        do_op(0, 2'b00, 32'h81, 1, 0, r, c);
        chk("sll8_81", 64'(r), 64'h02);
        chk("sll8_81_carry", 64'(c), 64'd1);
        do_op(1, 2'b11, 32'h8421, 15, 0, r, c);
        chk("rol_8421_15", 64'(r), 64'hC210);
        for (int m = 0; m < 4; m++) begin
            do_op(1, 2'(m), 32'hBEEF, 0, 0, r, c);
            chk("zero_amt", 64'(r), 64'hBEEF);
        end

        // Re-pulsed start and changed operands while busy are ignored.
        do_op(1, 2'b00, 32'h00F3, 5, 1, r, c);
        chk("disturb_result", 64'(r), 64'h1E60);

        // start held high: done pulses spaced amount+2 apart.
        begin
            int d1 = 0, d2 = 0;
            @(negedge clk);
            mode = 2'b01; data = 32'h0000_F00F; amount = 5'd3; start_v[1] = 1'b1;
            @(posedge clk);
            for (int cyc = 1; cyc <= 40 && d2 == 0; cyc++) begin
                @(negedge clk);
                if (done_v[1]) begin
                    chk("held_result", 64'(res_v[1]), 64'h1E01);
                    if (d1 == 0) d1 = cyc; else d2 = cyc;
                end
            end
            start_v[1] = 1'b0;
            chk("held_first", 64'(d1), 64'd4);
            chk("held_spacing", 64'(d2 - d1), 64'd5);
            repeat (2) @(negedge clk);
        end

        // Reset in cycle 4 of a long SLL aborts without done.
        begin
            bit saw_done = 0;
            @(negedge clk);
            mode = 2'b00; data = 32'h1234; amount = 5'd10; start_v[1] = 1'b1;
            @(posedge clk);
            for (int cyc = 1; cyc <= 3; cyc++) begin
                @(negedge clk);
                start_v[1] = 1'b0;
            end
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("abort_busy", 64'(busy_v[1]), 64'd0);
            chk("abort_result", 64'(res_v[1]), 64'd0);
            chk("abort_carry", 64'(carry_v[1]), 64'd0);
            for (int cyc = 0; cyc < 15; cyc++) begin
                @(negedge clk);
                if (done_v[1]) saw_done = 1;
            end
            chk("abort_no_done", 64'(saw_done), 64'd0);
            do_op(1, 2'b00, 32'd1, 3, 0, r, c);
            chk("after_abort", 64'(r), 64'd8);
        end

        // reset and start on the same edge: start is lost.
        @(negedge clk);
        reset = 1'b1; start_v[2] = 1'b1; data = 32'hFFFF; amount = 5'd4;
        @(negedge clk);
        reset = 1'b0; start_v[2] = 1'b0;
        chk("rst_prio_busy", 64'(busy_v[2]), 64'd0);
        chk("rst_prio_result", 64'(res_v[2]), 64'd0);

        // Random operations across widths, modes and amounts.
        for (int i = 0; i < 300; i++) begin
            int u, a;
            u = int'($urandom_range(0, 2));
            a = int'($urandom_range(0, wof(u) - 1));
            do_op(u, 2'($urandom), $urandom, a, ($urandom_range(0, 3) == 0), r, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
